// File: rtl/bank_pkg.sv
// Shared definitions for the 4-bank storage request path.
package bank_pkg;

    localparam int N_BANKS    = 4;
    localparam int BANK_IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } enc_state_t;

endpackage

// File: rtl/bank_req_enc_prio_pick4.sv
// prio_pick4: combinational 4-way picker. Returns the first set bit of
// cand found when searching upward from start (wrapping modulo 4).
module prio_pick4
    import bank_pkg::*;
(
    input  logic [N_BANKS-1:0]    cand,
    input  logic [BANK_IDX_W-1:0] start,
    output logic [BANK_IDX_W-1:0] idx,
    output logic                  any
);

    logic                  found;
    logic [BANK_IDX_W-1:0] pos;

    // Rotating search for the first candidate at or after start
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        any   = |cand;
        for (int unsigned k = 0; k < N_BANKS; k++) begin
            pos = start + BANK_IDX_W'(k);
            if (!found && cand[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_req_enc.sv
// bank_req_enc: latches per-bank request pulses and issues them one at a
// time as a 2-bit index with a valid/ready handshake.
// Build option: define ENC_RR_EN for round-robin selection; otherwise the
// lowest pending index always wins.
module bank_req_enc
    import bank_pkg::*;
#(
    parameter int N     = N_BANKS,
    parameter int IDX_W = BANK_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    input  logic             ready,
    output logic [N-1:0]     pending
);

    enc_state_t      state, state_n;
    logic [N-1:0]    cand;
    logic [N-1:0]    pending_n;
    logic [IDX_W-1:0] idx_n;
    logic            valid_n;
    logic [IDX_W-1:0] pick_idx;
    logic            pick_any;
    logic            load;
    logic [IDX_W-1:0] ptr;

`ifdef ENC_RR_EN
    logic [IDX_W-1:0] ptr_n;

    // Round-robin pointer: next search starts just past the last winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_n;
        end
    end

    // Advance the pointer only when a new index is loaded
    always_comb begin
        ptr_n = ptr;
        if (load) begin
            ptr_n = pick_idx + IDX_W'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    assign cand = pending | req;

    prio_pick4 u_pick (
        .cand  (cand),
        .start (ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // State, offered index and pending set registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            valid   <= 1'b0;
            pending <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            valid   <= valid_n;
            pending <= pending_n;
        end
    end

    // Next-state logic: load a new index when idle or when the current one
    // is accepted; new requests always merge into the pending set
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        valid_n   = valid;
        pending_n = cand;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    load = 1'b1;
                end
            end
            OFFER: begin
                if (ready) begin
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
        if (load) begin
            idx_n               = pick_idx;
            valid_n             = 1'b1;
            pending_n[pick_idx] = 1'b0;
            state_n             = OFFER;
        end
    end

endmodule

// File: doc/bank_req_enc.md
# bank_req_enc

Sequential request encoder for the 4-bank data storage system. It latches per-bank request pulses into a pending set and issues them one at a time as a 2-bit bank index with a valid/ready handshake. The downstream consumer is the bank-select path, whose 2-to-4 decoder turns the index back into a one-hot bank enable. It is the encoding end of that bank-select interface and serialises concurrent bank requests so that no request is lost.

## Interface
Parameters:
- `N`, default 4: number of request lines; the block supports only 4.
- `IDX_W`, default 2: index width; fixed at log2(N).

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, N: request bits; each bit set in a cycle registers one request for that bank.
- `idx`, output, IDX_W: encoded bank index being offered.
- `valid`, output, 1: `idx` holds a pending request.
- `ready`, input, 1: consumer accepts `idx` this cycle when `valid` is 1.
- `pending`, output, N: requests latched but not yet issued; excludes the bit currently offered.

## Operation
- Reset values: `idx`=0, `valid`=0, `pending`=0, state=IDLE, round-robin pointer=0.
- Define `cand` = `pending` | `req`. All `req` bits are OR-ed into `pending` every cycle; no request is ever dropped.
- Two states: IDLE and OFFER.
- IDLE:
  - If `cand`==0, stay in IDLE.
  - Otherwise, select index s from `cand`. Set `idx`=s and `valid`=1. Set `pending` = `cand` with bit s cleared. Go to OFFER.
- OFFER with `ready`=0:
  - `idx` and `valid` hold steady.
  - `pending` |= `req`.
- OFFER with `ready`=1 (a transfer occurs):
  - Recompute `cand` = `pending` | `req`.
  - If `cand`!=0, select the next s, load `idx`=s, clear bit s, and stay in OFFER. This gives back-to-back issue with no bubble.
  - If `cand`==0, set `valid`=0 and return to IDLE.
- A `req` bit equal to the offered index while in OFFER counts as a new request. It sets `pending`[idx] and is issued again later.
- Selection, with `ENC_RR_EN` defined: round-robin. Search starts at the pointer and wraps modulo 4. After each selection, pointer = s+1 mod 4 (3 wraps to 0).
- Selection, without `ENC_RR_EN`: fixed priority, lowest index first. No pointer register exists.

## Timing
- Latency is 1 cycle. A `req` bit sampled at edge k in IDLE gives `valid`=1 with that `idx` after edge k.
- Throughput is one index per cycle while `ready`=1 and requests remain.
- `idx` and `valid` are registered outputs. There is no combinational path from `req` or `ready` to any output.
- `ready` has no effect while `valid`=0.
- Simultaneous events: a transfer and a new `req` in the same cycle are both honoured. The new request joins `cand` before selection.
- Reset asserted mid-offer: all outputs clear immediately (asynchronous). Pending requests are discarded.
- After deassertion, the first edge behaves as IDLE.

## Configuration
- Macro: `ENC_RR_EN`.
- Defined: round-robin selection with a 2-bit pointer. Every bank with a continuously reasserted request is served within 4 transfers.
- Undefined: fixed priority, lowest index first. Bank 0 can starve banks 1–3. Area is smaller.

## Structure
- Shared package `bank_pkg`:
  - Constants `N_BANKS`=4 and `BANK_IDX_W`=2.
  - State enum `enc_state_t` {IDLE, OFFER}.
- Sub-module `prio_pick4`: combinational.
  - Inputs: 4-bit candidate vector and a 2-bit start pointer. The pointer is tied to 0 when `ENC_RR_EN` is undefined.
  - Outputs: 2-bit index and an `any` flag.
- Top level holds the state register, the `pending` register, the output registers and the pointer register.

## Test plan
- Reset, then a single pulse `req`=4'b0100 in IDLE with `ready`=1 → next cycle `idx`=2 and `valid`=1. The cycle after that, `valid`=0 and `pending`=0.
- `req`=4'b1011 for one cycle, `ready`=1, `ENC_RR_EN` defined with pointer 0 → `idx` sequence 0,1,3 on consecutive cycles with no gaps, then `valid`=0.
- Same stimulus with `ENC_RR_EN` undefined, `req`=4'b1111 held for 8 cycles → index 0 issued every cycle. With the macro defined → sequence 0,1,2,3,0,1,2,3.
- Backpressure: `req`=4'b0011 with `ready`=0 for 5 cycles → `idx`=0 held and `pending`=4'b0010. Raise `ready` → `idx`=1 next cycle.
- Offered index re-requested: in OFFER with `idx`=1, pulse `req`=4'b0010 while `ready`=0 → after the transfer, index 1 is issued a second time.
- Assert `rst_n`=0 mid-OFFER with `pending`=4'b1100 → `valid`, `idx` and `pending` become 0 without waiting for a clock edge. After release, no stale index is issued.
